// File: rtl/ram_access_arbiter.sv
// Shares one single-word DMA/RAM port among NCH requesters. Arbitration is round-robin
// or fixed priority under a runtime enable mask, and every transfer has a watchdog.
module ram_access_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_gnt,
    output logic [NCH-1:0]    ch_done,
    output logic [DW-1:0]     ch_rdata,
    output logic              timeout_err,
    output logic              busy,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DW-1:0]     ram_rdata,
    input  logic              ram_done_rd,
    input  logic              ram_done_wr
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = IW + 1;
    localparam logic [7:0] WDOG_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arbStateT;

    arbStateT       stateReg, stateNext;
    logic [IW-1:0]  idxReg, idxNext;
    logic [IW-1:0]  lastReg, lastNext;
    logic           weReg, weNext;
    logic [7:0]     wdogReg, wdogNext;

    logic [NCH-1:0] gntNext, doneNext;
    logic [DW-1:0]  rdataNext;
    logic [AW-1:0]  addrNext;
    logic [DW-1:0]  wdataNext;
    logic           toErrNext, busyNext, rdNext, wrNext;

    logic [NCH-1:0] elig;
    logic [IW-1:0]  winIdx;
    logic           winFound;
    logic [CW-1:0]  cand;
    logic           matchDone;
    logic           wdogHit;

    logic [AW-1:0]  addrArr  [NCH];
    logic [DW-1:0]  wdataArr [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign addrArr[gi]  = ch_addr[gi*AW +: AW];
        assign wdataArr[gi] = ch_wdata[gi*DW +: DW];
    end

    assign elig = ch_req & ch_en;

    // Scanning from the farthest candidate down to the nearest leaves the nearest winner last.
    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        cand     = '0;
        if (RR_MODE != 0) begin
            for (int off = NCH; off >= 1; off--) begin
                cand = {1'b0, lastReg} + CW'(off);
                if (cand >= CW'(NCH)) begin
                    cand = cand - CW'(NCH);
                end
                if (elig[cand[IW-1:0]]) begin
                    winIdx   = cand[IW-1:0];
                    winFound = 1'b1;
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    winIdx   = IW'(i);
                    winFound = 1'b1;
                end
            end
        end
    end

    assign matchDone = weReg ? ram_done_wr : ram_done_rd;
    assign wdogHit   = (TIMEOUT != 0) && (wdogReg == WDOG_LAST);

    always_comb begin
        stateNext = stateReg;
        idxNext   = idxReg;
        weNext    = weReg;
        lastNext  = lastReg;
        wdogNext  = wdogReg;
        gntNext   = '0;
        doneNext  = '0;
        rdataNext = ch_rdata;
        toErrNext = 1'b0;
        addrNext  = ram_addr;
        wdataNext = ram_wdata;
        rdNext    = 1'b0;
        wrNext    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (winFound) begin
                    idxNext          = winIdx;
                    weNext           = ch_we[winIdx];
                    addrNext         = addrArr[winIdx];
                    wdataNext        = wdataArr[winIdx];
                    gntNext[winIdx]  = 1'b1;
                    rdNext           = ~ch_we[winIdx];
                    wrNext           = ch_we[winIdx];
                    stateNext        = ISSUE;
                end
            end
            ISSUE: begin
                wdogNext  = '0;
                stateNext = WAIT;
            end
            WAIT: begin
                if (matchDone) begin
                    doneNext[idxReg] = 1'b1;
                    if (!weReg) begin
                        rdataNext = ram_rdata;
                    end
                    lastNext  = idxReg;
                    stateNext = IDLE;
                end else if (wdogHit) begin
                    doneNext[idxReg] = 1'b1;
                    toErrNext        = 1'b1;
                    lastNext         = idxReg;
                    stateNext        = IDLE;
                end else begin
                    wdogNext = wdogReg + 8'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            stateReg    <= IDLE;
            idxReg      <= '0;
            weReg       <= 1'b0;
            lastReg     <= IW'(NCH - 1);
            wdogReg     <= '0;
            ch_gnt      <= '0;
            ch_done     <= '0;
            ch_rdata    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            idxReg      <= idxNext;
            weReg       <= weNext;
            lastReg     <= lastNext;
            wdogReg     <= wdogNext;
            ch_gnt      <= gntNext;
            ch_done     <= doneNext;
            ch_rdata    <= rdataNext;
            timeout_err <= toErrNext;
            busy        <= busyNext;
            ram_addr    <= addrNext;
            ram_wdata   <= wdataNext;
            ram_rd      <= rdNext;
            ram_wr      <= wrNext;
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: instance 0 is round-robin, instance 1 fixed priority,
// both with an 8-cycle watchdog and a small DMA responder each.
module tb_ram_access_arbiter;
    logic        clk;
    logic        rstN;
    logic [3:0]  chEn, chReq, chWe;
    logic [63:0] chAddr, chWdata;
    logic [15:0] dmaData;
    int          dmaDelay;
    logic        dmaEn, spurRd;

    logic [3:0]  gnt [2];
    logic [3:0]  done [2];
    logic [15:0] rdata [2];
    logic [15:0] ramAddr [2];
    logic [15:0] ramWdata [2];
    logic        toErr [2];
    logic        busy [2];
    logic        ramRd [2];
    logic        ramWr [2];

    int nCmp = 0;
    int nBad = 0;
    int cyc = 0;
    int doneCount = 0;
    int wrRun = 0;
    int gntLog0[$];
    int gntLog1[$];
    int gntCyc[$];
    int wrRuns[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic dRd, dWr, pendWe;
        int   cnt;

        ram_access_arbiter #(
            .NCH(4), .AW(16), .DW(16), .RR_MODE((gi == 0) ? 1 : 0), .TIMEOUT(8)
        ) dut (
            .clk(clk),
            .RST(rstN),
            .ch_en(chEn),
            .ch_req(chReq),
            .ch_we(chWe),
            .ch_addr(chAddr),
            .ch_wdata(chWdata),
            .ch_gnt(gnt[gi]),
            .ch_done(done[gi]),
            .ch_rdata(rdata[gi]),
            .timeout_err(toErr[gi]),
            .busy(busy[gi]),
            .ram_addr(ramAddr[gi]),
            .ram_wdata(ramWdata[gi]),
            .ram_rd(ramRd[gi]),
            .ram_wr(ramWr[gi]),
            .ram_rdata(dmaData),
            .ram_done_rd(dRd | spurRd),
            .ram_done_wr(dWr)
        );

        // DMA model: done arrives dmaDelay cycles after the strobe (1 = first WAIT cycle).
        always @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                dRd <= 1'b0; dWr <= 1'b0; cnt <= 0; pendWe <= 1'b0;
            end else begin
                dRd <= 1'b0;
                dWr <= 1'b0;
                if (ramRd[gi] || ramWr[gi]) begin
                    if (dmaDelay <= 1) begin
                        dRd <= dmaEn & ramRd[gi];
                        dWr <= dmaEn & ramWr[gi];
                    end else begin
                        cnt    <= dmaDelay - 1;
                        pendWe <= ramWr[gi];
                    end
                end else if (cnt != 0) begin
                    cnt <= cnt - 1;
                    if (cnt == 1) begin
                        dRd <= dmaEn & ~pendWe;
                        dWr <= dmaEn & pendWe;
                    end
                end
            end
        end
    end

    function automatic int ohIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gnt[0] != 4'd0) begin
            gntLog0.push_back(ohIdx(gnt[0]));
            gntCyc.push_back(cyc);
        end
        if (gnt[1] != 4'd0) gntLog1.push_back(ohIdx(gnt[1]));
        if (done[0] != 4'd0) doneCount++;
        if (ramWr[0]) wrRun++;
        else if (wrRun > 0) begin
            wrRuns.push_back(wrRun);
            wrRun = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitDone0(input int budget, input string tag);
        int n = 0;
        while (done[0] == 4'd0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done[0] != 4'd0), 32'd1);
    endtask

    task automatic waitLog0(input int want, input int budget, input string tag);
        int n = 0;
        while (gntLog0.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(gntLog0.size() >= want), 32'd1);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while ((busy[0] || busy[1] || done[0] != 4'd0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy[0] | busy[1]), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        int early;
        int dc;
        rstN = 1'b0; chEn = 4'h0; chReq = 4'h0; chWe = 4'h0;
        chAddr  = {16'h0C30, 16'h0040, 16'h0A10, 16'h0900};
        chWdata = {16'hD3D3, 16'hC2C2, 16'h1234, 16'hA0A0};
        dmaData = 16'hBEEF; dmaDelay = 3; dmaEn = 1'b1; spurRd = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_gnt", 32'(gnt[0]), 32'h0);
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_rdata", 32'(rdata[0]), 32'h0);
        check("rst_strobes", 32'({ramRd[0], ramWr[0], toErr[0]}), 32'h0);
        rstN = 1'b1;
        @(negedge clk);

        // T1 single read on channel 2
        chEn = 4'hF; chReq = 4'b0100;
        @(negedge clk);
        check("t1_gnt", 32'(gnt[0]), 32'b0100);
        check("t1_ram_rd", 32'({ramRd[0], ramWr[0]}), 32'b10);
        check("t1_addr", 32'(ramAddr[0]), 32'h0040);
        check("t1_busy", 32'(busy[0]), 32'h1);
        chReq = 4'h0;
        @(negedge clk);
        check("t1_rd_width", 32'({ramRd[0], gnt[0]}), 32'h0);
        waitDone0(10, "t1_done_bound");
        check("t1_done", 32'(done[0]), 32'b0100);
        check("t1_rdata", 32'(rdata[0]), 32'hBEEF);
        check("t1_toerr", 32'(toErr[0]), 32'h0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done[0]), 32'h0);
        check("t1_rdata_hold", 32'(rdata[0]), 32'hBEEF);
        waitIdle("t1_idle");

        // T2 round-robin vs fixed priority, all channels requesting
        doReset();
        gntLog0.delete(); gntLog1.delete();
        dmaDelay = 1; chEn = 4'hF; chWe = 4'h0; chReq = 4'hF;
        waitLog0(8, 60, "t2_bound");
        chReq = 4'h0;
        waitIdle("t2_idle");
        check("t2_fp_count", 32'(gntLog1.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_rr_%0d", i), 32'(gntLog0[i]), 32'(i % 4));
            check($sformatf("t2_fp_%0d", i), 32'(gntLog1[i]), 32'd0);
        end

        // T3 enable mask 1010
        doReset();
        gntLog0.delete(); gntLog1.delete();
        chEn = 4'b1010; chReq = 4'hF;
        waitLog0(4, 40, "t3_bound");
        chReq = 4'h0;
        waitIdle("t3_idle");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rr_%0d", i), 32'(gntLog0[i]), ((i % 2) == 0) ? 32'd1 : 32'd3);
            check($sformatf("t3_fp_%0d", i), 32'(gntLog1[i]), 32'd1);
        end

        // T3b clearing the mask mid-WAIT still completes the transfer
        gntLog0.delete(); gntLog1.delete();
        dmaDelay = 4; chEn = 4'hF; chReq = 4'b0001;
        @(negedge clk);
        check("t3b_gnt", 32'(gnt[0]), 32'b0001);
        @(negedge clk);
        chEn = 4'h0;
        waitDone0(10, "t3b_done_bound");
        check("t3b_done", 32'(done[0]), 32'b0001);
        repeat (6) @(negedge clk);
        check("t3b_no_regrant", 32'(gntLog0.size()), 32'd1);
        chReq = 4'h0; chEn = 4'hF;
        waitIdle("t3b_idle");

        // T4 watchdog on a write to channel 1 with a spurious read done
        dmaEn = 1'b0; dmaData = 16'h5A5A; chWe = 4'b0010; chReq = 4'b0010;
        @(negedge clk);
        check("t4_gnt", 32'(gnt[0]), 32'b0010);
        check("t4_ram_wr", 32'({ramRd[0], ramWr[0]}), 32'b01);
        check("t4_wdata", 32'(ramWdata[0]), 32'h1234);
        chReq = 4'h0;
        early = 0;
        for (int i = 1; i <= 9; i++) begin
            spurRd = (i == 3);
            @(negedge clk);
            if (i < 9 && (done[0] != 4'd0 || toErr[0])) early++;
        end
        spurRd = 1'b0;
        check("t4_early_done", 32'(early), 32'd0);
        check("t4_done", 32'(done[0]), 32'b0010);
        check("t4_toerr", 32'(toErr[0]), 32'h1);
        check("t4_rdata_kept", 32'(rdata[0]), 32'hBEEF);
        @(negedge clk);
        check("t4_toerr_pulse", 32'({toErr[0], done[0]}), 32'h0);
        dmaEn = 1'b1; chWe = 4'h0;
        waitIdle("t4_idle");

        // T5 asynchronous reset during WAIT
        dmaDelay = 5; chReq = 4'hF;
        @(negedge clk);
        check("t5_gnt", 32'(gnt[0]), 32'b0100);
        @(negedge clk); @(negedge clk);
        check("t5_busy", 32'(busy[0]), 32'h1);
        dc = doneCount;
        #2 rstN = 1'b0;
        #1;
        check("t5_async_busy", 32'(busy[0]), 32'h0);
        check("t5_async_addr", 32'(ramAddr[0]), 32'h0);
        check("t5_async_rdata", 32'(rdata[0]), 32'h0);
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(doneCount), 32'(dc));
        gntLog0.delete(); gntLog1.delete();
        rstN = 1'b1;
        waitLog0(1, 5, "t5_regrant_bound");
        check("t5_first_gnt", 32'(gntLog0[0]), 32'd0);
        chReq = 4'h0;
        waitIdle("t5_idle");

        // T6 back-to-back writes on channels 0 and 3
        gntLog0.delete(); gntLog1.delete(); gntCyc.delete(); wrRuns.delete();
        dmaDelay = 1; chWe = 4'hF; chReq = 4'b1001;
        waitLog0(2, 20, "t6_bound");
        chReq = 4'h0;
        waitIdle("t6_idle");
        @(negedge clk);
        check("t6_gnt0", 32'(gntLog0[0]), 32'd3);
        check("t6_gnt1", 32'(gntLog0[1]), 32'd0);
        check("t6_spacing", 32'(gntCyc[1] - gntCyc[0]), 32'd3);
        check("t6_wr_count", 32'(wrRuns.size()), 32'd2);
        for (int i = 0; i < 2; i++) check($sformatf("t6_wr_width_%0d", i), 32'(wrRuns[i]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench timed out");
    end
endmodule
